bsg_credit_counter_down: RTL and testbench

- Sender-side credit counter, the consuming end of an up-counting credit/occupancy tracker on a ready-valid link.
- Resets full, decrements one per send, increments by a batch of returned credits, and gates sends when credits run out.
- Adds a flush/drain state machine: sends are blocked until every credit has returned, then completion is signalled.
- Sits between a producer's valid/ready logic and the link it feeds.

---
 rtl/bsg_credit_counter_down.sv | 107 ++++++++++
 tb/tb_bsg_credit_counter_down.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bsg_credit_counter_down.sv
// Sender-side credit counter with a flush/drain FSM that blocks sends until every credit is back.
// Optional sticky underflow/overflow flag: define BSG_CREDIT_COUNTER_ERROR_EN.
module bsg_credit_counter_down #(
  parameter int max_val_p  = 15,
  parameter int init_val_p = max_val_p,
  parameter int max_step_p = 1,
  localparam int ptr_w  = $clog2(max_val_p+1),
  localparam int step_w = $clog2(max_step_p+1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              set_i,
  input  logic [ptr_w-1:0]  val_i,
  input  logic              down_i,
  input  logic [step_w-1:0] up_i,
  input  logic              flush_i,
  output logic [ptr_w-1:0]  count_o,
  output logic              avail_o,
  output logic              drained_o,
  output logic              error_o
);

  localparam logic [ptr_w:0]   max_c  = (ptr_w+1)'(max_val_p);
  localparam logic [ptr_w-1:0] init_c = ptr_w'(init_val_p);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e           state_r, state_n;
  logic [ptr_w-1:0] count_r, count_n;
  logic [ptr_w:0]   sum;
  logic             dec, underflow, overflow, drained_r;

  // One extra bit of headroom so a large credit return cannot wrap before saturation.
  always_comb begin
    dec       = down_i && (count_r != '0);
    underflow = 1'b0;
    overflow  = 1'b0;
    sum       = '0;
    if (set_i) begin
      sum = {1'b0, val_i};
    end else begin
      sum       = {1'b0, count_r} - (ptr_w+1)'(dec) + (ptr_w+1)'(up_i);
      underflow = down_i && (count_r == '0);
      overflow  = (sum > max_c);
    end
    count_n = (sum > max_c) ? max_c[ptr_w-1:0] : sum[ptr_w-1:0];
  end

  // Drain completion looks at the registered count, not the incoming update.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (flush_i) state_n = DRAIN;
      DRAIN:   if ({1'b0, count_r} == max_c) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r   <= init_c;
      state_r   <= IDLE;
      drained_r <= 1'b0;
    end else begin
      count_r   <= count_n;
      state_r   <= state_n;
      drained_r <= (state_n == DONE);
    end
  end

  assign count_o   = count_r;
  assign avail_o   = (count_r != '0) && (state_r == IDLE);
  assign drained_o = drained_r;

`ifdef BSG_CREDIT_COUNTER_ERROR_EN
  logic error_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)                    error_r <= 1'b0;
    else if (underflow || overflow) error_r <= 1'b1;
  end

  assign error_o = error_r;

`ifndef SYNTHESIS
  logic [31:0] cycle_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) cycle_r <= '0;
    else         cycle_r <= cycle_r + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (underflow) $error("bsg_credit_counter_down: underflow (down at zero) cycle %0d", cycle_r);
      if (overflow)  $error("bsg_credit_counter_down: overflow (sum %0d) cycle %0d", sum, cycle_r);
    end
  end
`endif
`else
  logic unused_err;
  assign unused_err = underflow ^ overflow;
  assign error_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_credit_counter_down.sv
// Directed + random bench for bsg_credit_counter_down against a spec-level model (two configurations).
module tb_bsg_credit_counter_down;

  localparam int PH_IDLE = 0, PH_DRAIN = 1, PH_DONE = 2;

  logic       clk = 1'b0;
  logic       rst, set, dn, fl, up_a;
  logic [3:0] val;
  logic [1:0] up_b;

  logic [3:0] cnt_a, cnt_b;
  logic       av_a, dr_a, er_a, av_b, dr_b, er_b;

  int checks = 0;
  int errors = 0;

  // model: count, phase, sticky error per instance
  int mx[2] = '{15, 12};
  int mc[2];
  int ms[2];
  bit me[2];

  always #5 clk = ~clk;

  bsg_credit_counter_down #(.max_val_p(15)) dut_a (
    .clk_i(clk), .reset_i(rst), .set_i(set), .val_i(val), .down_i(dn), .up_i(up_a),
    .flush_i(fl), .count_o(cnt_a), .avail_o(av_a), .drained_o(dr_a), .error_o(er_a)
  );

  bsg_credit_counter_down #(.max_val_p(12), .max_step_p(3)) dut_b (
    .clk_i(clk), .reset_i(rst), .set_i(set), .val_i(val), .down_i(dn), .up_i(up_b),
    .flush_i(fl), .count_o(cnt_b), .avail_o(av_b), .drained_o(dr_b), .error_o(er_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input int up);
    int total;
    if (rst) begin
      mc[i] = mx[i]; ms[i] = PH_IDLE; me[i] = 1'b0;
      return;
    end
    if (ms[i] == PH_IDLE && fl)             ms[i] = PH_DRAIN;
    else if (ms[i] == PH_DRAIN && mc[i] == mx[i]) ms[i] = PH_DONE;
    else if (ms[i] == PH_DONE)              ms[i] = PH_IDLE;
    if (set) begin
      mc[i] = (int'(val) > mx[i]) ? mx[i] : int'(val);
    end else begin
      total = mc[i] + up;
      if (dn) begin
        if (mc[i] == 0) me[i] = 1'b1;
        else            total = total - 1;
      end
      if (total > mx[i]) begin
        total = mx[i]; me[i] = 1'b1;
      end
      mc[i] = total;
    end
  endtask

  function automatic int err_exp(input int i);
`ifdef BSG_CREDIT_COUNTER_ERROR_EN
    return int'(me[i]);
`else
    return 0 * i;
`endif
  endfunction

  task automatic tick();
    model_step(0, int'(up_a));
    model_step(1, int'(up_b));
    @(posedge clk);
    #1;
    chk("a.count",   32'(cnt_a), mc[0]);
    chk("a.avail",   32'(av_a),  int'(mc[0] != 0 && ms[0] == PH_IDLE));
    chk("a.drained", 32'(dr_a),  int'(ms[0] == PH_DONE));
    chk("a.error",   32'(er_a),  err_exp(0));
    chk("b.count",   32'(cnt_b), mc[1]);
    chk("b.avail",   32'(av_b),  int'(mc[1] != 0 && ms[1] == PH_IDLE));
    chk("b.drained", 32'(dr_b),  int'(ms[1] == PH_DONE));
    chk("b.error",   32'(er_b),  err_exp(1));
  endtask

  task automatic drv(input bit r, input bit s, input logic [3:0] v, input bit d,
                     input bit ua, input logic [1:0] ub, input bit f);
    rst = r; set = s; val = v; dn = d; up_a = ua; up_b = ub; fl = f;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; set = 1'b0; val = '0; dn = 1'b0; up_a = 1'b0; up_b = '0; fl = 1'b0;
    #1;
    // reset state
    drv(1, 0, 4'd0, 0, 0, 2'd0, 0);
    // drain credits to zero, then one extra down at zero
    repeat (16) drv(0, 0, 4'd0, 1, 0, 2'd0, 0);
    // simultaneous down and up
    drv(0, 1, 4'd5, 0, 0, 2'd0, 0);
    drv(0, 0, 4'd0, 1, 1, 2'd1, 0);
    // overflow on large credit return (b saturates at 12)
    drv(0, 1, 4'd14, 0, 0, 2'd0, 0);
    drv(0, 0, 4'd0, 0, 1, 2'd3, 0);
    // set overrides up/down; load value saturates on b
    drv(0, 1, 4'd7, 1, 1, 2'd1, 0);
    drv(0, 1, 4'd15, 0, 0, 2'd0, 0);
    // flush at 12, return one credit per cycle until drained
    drv(0, 1, 4'd12, 0, 0, 2'd0, 0);
    drv(0, 0, 4'd0, 0, 0, 2'd0, 1);
    repeat (7) drv(0, 0, 4'd0, 0, 1, 2'd0, 0);
    // flush with count already full
    drv(0, 0, 4'd0, 0, 0, 2'd0, 1);
    repeat (3) drv(0, 0, 4'd0, 0, 0, 2'd0, 0);
    // reset mid-drain with count 9
    drv(0, 1, 4'd9, 0, 0, 2'd0, 0);
    drv(0, 0, 4'd0, 0, 0, 2'd0, 1);
    drv(0, 0, 4'd0, 0, 0, 2'd0, 0);
    drv(1, 0, 4'd0, 0, 0, 2'd0, 0);
    drv(0, 0, 4'd0, 0, 0, 2'd0, 0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      drv(($urandom_range(99) < 2), ($urandom_range(99) < 8), 4'($urandom_range(15)),
          1'($urandom_range(1)), ($urandom_range(99) < 40), 2'($urandom_range(3)),
          ($urandom_range(99) < 6));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
